// File: rtl/nanov_serial_alu_if.sv
// Operand, result and handshake bundle between the nanoV serial ALU and its
// surrounding core (sequencer plus register file).
interface nanov_serial_alu_if;
  logic       start;
  logic [3:0] op;
  logic [4:0] shamt;
  logic       data_rs1;
  logic       data_rs2;
  logic [4:0] counter;
  logic       data_rd;
  logic       wr_en;
  logic       busy;
  logic       done;
  logic       zero;

  modport master (
    output start, op, shamt, data_rs1, data_rs2,
    input  counter, data_rd, wr_en, busy, done, zero
  );

  modport slave (
    input  start, op, shamt, data_rs1, data_rs2,
    output counter, data_rd, wr_en, busy, done, zero
  );
endinterface

// File: rtl/nanov_serial_alu.sv
// Bit-serial RV32E execute unit: single 32-cycle pass for add/sub/logic ops,
// capture pass plus emit pass for shifts and set-less-than.
module nanov_serial_alu (
  input  logic              clk,
  input  logic              rstn,
  nanov_serial_alu_if.slave bus
);
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  typedef enum logic [1:0] {IDLE, RUN, CAPTURE, EMIT} state_t;

  state_t      state_reg;
  logic [4:0]  counter_reg;
  logic [3:0]  op_reg;
  logic [4:0]  shamt_reg;
  logic        carry_reg;
  logic [31:0] shift_buf_reg;
  logic        flag_reg;
  logic        ones_reg;
  logic        busy_reg;
  logic        wr_en_reg;
  logic        done_reg;
  logic        zero_reg;

  logic        b_eff;
  logic        sum_bit;
  logic        carry_next;
  logic [4:0]  src_dn;
  logic [5:0]  src_up;
  logic        emit_bit;
  logic        rd_bit;

  // SUB and both compares run a + ~b + 1 through the same serial adder.
  always_comb begin
    b_eff      = bus.data_rs2 ^ ((op_reg == OP_SUB) || (op_reg == OP_SLT) || (op_reg == OP_SLTU));
    sum_bit    = bus.data_rs1 ^ b_eff ^ carry_reg;
    carry_next = (bus.data_rs1 & b_eff) | (carry_reg & (bus.data_rs1 ^ b_eff));
    src_dn     = counter_reg - shamt_reg;
    src_up     = {1'b0, counter_reg} + {1'b0, shamt_reg};

    emit_bit = 1'b0;
    case (op_reg)
      OP_SLT, OP_SLTU: emit_bit = (counter_reg == 5'd0) ? flag_reg : 1'b0;
      OP_SLL:          emit_bit = (counter_reg >= shamt_reg) ? shift_buf_reg[src_dn] : 1'b0;
      OP_SRL:          emit_bit = !src_up[5] ? shift_buf_reg[src_up[4:0]] : 1'b0;
      OP_SRA:          emit_bit = !src_up[5] ? shift_buf_reg[src_up[4:0]] : shift_buf_reg[31];
      default:         emit_bit = 1'b0;
    endcase

    rd_bit = 1'b0;
    if (state_reg == RUN) begin
      case (op_reg)
        OP_ADD, OP_SUB: rd_bit = sum_bit;
        OP_AND:         rd_bit = bus.data_rs1 & bus.data_rs2;
        OP_OR:          rd_bit = bus.data_rs1 | bus.data_rs2;
        OP_XOR:         rd_bit = bus.data_rs1 ^ bus.data_rs2;
        default:        rd_bit = 1'b0;
      endcase
    end else if (state_reg == EMIT) begin
      rd_bit = emit_bit;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      counter_reg   <= 5'd0;
      op_reg        <= OP_ADD;
      shamt_reg     <= 5'd0;
      carry_reg     <= 1'b0;
      shift_buf_reg <= 32'd0;
      flag_reg      <= 1'b0;
      ones_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      wr_en_reg     <= 1'b0;
      done_reg      <= 1'b0;
      zero_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            op_reg      <= bus.op;
            shamt_reg   <= bus.shamt;
            counter_reg <= 5'd0;
            carry_reg   <= (bus.op == OP_SUB) || (bus.op == OP_SLT) || (bus.op == OP_SLTU);
            flag_reg    <= 1'b0;
            ones_reg    <= 1'b0;
            zero_reg    <= 1'b0;
            busy_reg    <= 1'b1;
            if ((bus.op >= OP_SLT) && (bus.op <= OP_SRA)) begin
              state_reg <= CAPTURE;
              wr_en_reg <= 1'b0;
            end else begin
              state_reg <= RUN;
              wr_en_reg <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          shift_buf_reg <= {bus.data_rs1, shift_buf_reg[31:1]};
          carry_reg     <= carry_next;
          counter_reg   <= counter_reg + 5'd1;
          if (counter_reg == 5'd31) begin
            // Signed compare: differing signs decide directly, else the difference sign.
            if (op_reg == OP_SLT)
              flag_reg <= (bus.data_rs1 != bus.data_rs2) ? bus.data_rs1 : sum_bit;
            else
              flag_reg <= ~carry_next;
            state_reg <= EMIT;
            wr_en_reg <= 1'b1;
          end
        end
        RUN, EMIT: begin
          carry_reg   <= carry_next;
          ones_reg    <= ones_reg | rd_bit;
          counter_reg <= counter_reg + 5'd1;
          if (counter_reg == 5'd31) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            wr_en_reg <= 1'b0;
            done_reg  <= 1'b1;
            zero_reg  <= ~(ones_reg | rd_bit);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.counter = counter_reg;
  assign bus.data_rd = rd_bit;
  assign bus.wr_en   = wr_en_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.zero    = zero_reg;
endmodule

// File: tb/tb_nanov_serial_alu.sv
// Directed plus randomized checks of nanov_serial_alu against a word-level model.
module tb_nanov_serial_alu;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  nanov_serial_alu_if alu_if ();

  nanov_serial_alu dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (alu_if)
  );

  int errors = 0;
  int checks = 0;
  logic [3:0] next_op;
  logic [4:0] next_sh;

  function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] a, b,
                                          input logic [4:0] sh);
    logic [31:0] r;
    case (o)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: r = (a < b) ? 32'd1 : 32'd0;
      4'd7: r = a << sh;
      4'd8: r = a >> sh;
      4'd9: r = $signed(a) >>> sh;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {20'd0, alu_if.counter, alu_if.data_rd, alu_if.wr_en, alu_if.busy,
            alu_if.done, alu_if.zero, 2'b00};
  endfunction

  // One operation; optional mid-run start pulse, mid-run reset, and a start on done.
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input string tag, input int inject_c,
                       input int rst_c, input bit b2b, input bit pre);
    logic [31:0] res = 32'd0;
    logic [31:0] exp = ref_alu(o, a, b, sh);
    bit two_pass = (o >= 4'd5) && (o <= 4'd9);
    int exp_first = two_pass ? 33 : 1;
    int exp_done  = two_pass ? 65 : 33;
    int wr_cnt = 0, first_wr = 0, done_c = 0;
    bit cnt_ok = 1'b1;
    logic busy_at_done = 1'b1;
    if (!pre) begin
      @(negedge clk);
      alu_if.start = 1'b1;
      alu_if.op    = o;
      alu_if.shamt = sh;
    end
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      alu_if.start    = 1'b0;
      alu_if.data_rs1 = a[alu_if.counter];
      alu_if.data_rs2 = b[alu_if.counter];
      #1;
      if (c == 1) begin
        check($sformatf("%s busy@T+1", tag), {31'd0, alu_if.busy}, 32'd1);
        check($sformatf("%s counter@T+1", tag), {27'd0, alu_if.counter}, 32'd0);
      end
      if (alu_if.wr_en) begin
        if (wr_cnt == 0) first_wr = c;
        if (alu_if.counter != 5'(c - exp_first)) cnt_ok = 1'b0;
        res[alu_if.counter] = alu_if.data_rd;
        wr_cnt++;
      end
      if (c == rst_c) begin
        rstn = 1'b0;
        #1;
        check($sformatf("%s async reset outputs", tag), out_vec(), 32'd0);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          if (k == 2) rstn = 1'b1;
          #1;
          check($sformatf("%s no done after reset %0d", tag, k), {31'd0, alu_if.done}, 32'd0);
        end
        $display("op=%0d %s a=%08h b=%08h sh=%0d aborted by reset at cycle %0d", o, tag, a, b, sh, c);
        return;
      end
      if (alu_if.done) begin
        done_c       = c;
        busy_at_done = alu_if.busy;
        if (b2b) begin
          alu_if.start = 1'b1;
          alu_if.op    = next_op;
          alu_if.shamt = next_sh;
        end
        break;
      end
      if (c == inject_c) begin
        alu_if.start = 1'b1;
        alu_if.op    = 4'd0;
      end
    end
    check($sformatf("%s done cycle", tag), done_c, exp_done);
    check($sformatf("%s wr_en count", tag), wr_cnt, 32);
    check($sformatf("%s first wr_en cycle", tag), first_wr, exp_first);
    check($sformatf("%s counter sequence", tag), {31'd0, cnt_ok}, 32'd1);
    check($sformatf("%s result", tag), res, exp);
    check($sformatf("%s zero", tag), {31'd0, alu_if.zero}, {31'd0, exp == 32'd0});
    check($sformatf("%s busy at done", tag), {31'd0, busy_at_done}, 32'd0);
    $display("op=%0d %s a=%08h b=%08h sh=%0d -> rd=%08h exp=%08h done@T+%0d", o, tag, a, b, sh,
             res, exp, done_c);
  endtask

  initial begin
    logic [3:0]  r_op;
    logic [31:0] r_a, r_b;
    logic [4:0]  r_sh;
    alu_if.start    = 1'b0;
    alu_if.op       = 4'd0;
    alu_if.shamt    = 5'd0;
    alu_if.data_rs1 = 1'b0;
    alu_if.data_rs2 = 1'b0;
    next_op = 4'd0;
    next_sh = 5'd0;
    repeat (3) @(negedge clk);
    check("reset outputs", out_vec(), 32'd0);
    rstn = 1'b1;

    do_op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  "ADD ovf",   0, 0, 0, 0);
    do_op(4'd1, 32'd5,         32'd7,         5'd0,  "SUB 5-7",   0, 0, 0, 0);
    do_op(4'd1, 32'd9,         32'd9,         5'd0,  "SUB 9-9",   0, 0, 0, 0);
    do_op(4'd5, 32'hFFFF_FFFF, 32'd1,         5'd0,  "SLT",       0, 0, 0, 0);
    do_op(4'd6, 32'hFFFF_FFFF, 32'd1,         5'd0,  "SLTU",      0, 0, 0, 0);
    do_op(4'd7, 32'd1,         32'd0,         5'd31, "SLL 31",    0, 0, 0, 0);
    do_op(4'd8, 32'h8000_0000, 32'd0,         5'd4,  "SRL 4",     0, 0, 0, 0);
    do_op(4'd9, 32'h8000_0000, 32'd0,         5'd4,  "SRA 4",     0, 0, 0, 0);
    do_op(4'd9, 32'h9234_5678, 32'd0,         5'd0,  "SRA 0",     0, 0, 0, 0);
    do_op(4'd8, 32'hA5C3_0F99, 32'h1234_5678, 5'd7,  "SRL inject", 11, 0, 0, 0);
    next_op = 4'd0;
    next_sh = 5'd0;
    do_op(4'd4, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 5'd0,  "XOR b2b",   0, 0, 1, 0);
    do_op(4'd0, 32'd12345,     32'd1111,      5'd0,  "ADD after", 0, 0, 0, 1);
    do_op(4'd9, 32'h8000_0000, 32'd0,         5'd4,  "SRA reset", 0, 38, 0, 0);
    do_op(4'd0, 32'd3,         32'd4,         5'd0,  "ADD 3+4",   0, 0, 0, 0);
    do_op(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, "reserved",  0, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      r_op = 4'($urandom_range(0, 10));
      r_a  = $urandom;
      r_b  = (i % 4 == 0) ? r_a : $urandom;
      r_sh = 5'($urandom_range(0, 31));
      do_op(r_op, r_a, r_b, r_sh, $sformatf("rand%0d", i), 0, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nanov_serial_alu.md
# nanov_serial_alu

Bit-serial execute unit for the nanoV RV32E core. It sits directly upstream of the register file. It consumes the LSB-first operand streams `data_rs1`/`data_rs2` and produces the `data_rd` write stream plus write enable and bit counter, over 32-cycle passes. Shifts and set-less-than need the whole operand before emitting bit 0, so they use a capture pass followed by an emit pass.

## Interface
- No parameters (XLEN fixed at 32; counter width fixed at 5).
- `clk`  in  1  core clock; all state on rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request; accepted only when `busy`=0.
- `op`  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA; 10-15 reserved. Sampled with `start`.
- `shamt`  in  5  shift amount, sampled with `start` (shift ops only).
- `data_rs1`  in  1  operand A bit `counter`, LSB first.
- `data_rs2`  in  1  operand B bit `counter`, LSB first.
- `counter`  out  5  current bit index, drives the register file `counter`.
- `data_rd`  out  1  result bit `counter`.
- `wr_en`  out  1  `data_rd` is valid and must be written to rd.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse after the last result bit.
- `zero`  out  1  1 when all 32 result bits were 0; valid while `done`=1, holds until next `start`.

## Operation
- States: IDLE, RUN (single-pass), CAPTURE, EMIT.
- IDLE + `start`: latch `op`/`shamt`, `counter`←0. Ops 0-4 and reserved go to RUN; ops 5-9 go to CAPTURE.
- RUN: 32 cycles, counter 0..31. `wr_en`=1. `data_rd` is combinational from `data_rs1`, `data_rs2` and the carry register.
  - ADD: sum = a^b^c, carry initialised to 0.
  - SUB: b inverted, carry initialised to 1.
  - AND/OR/XOR: bitwise.
  - Reserved ops: `data_rd`=0.
- CAPTURE: 32 cycles, `wr_en`=0, `data_rd`=0.
  - Shift ops: shift `data_rs1` into a 32-bit buffer.
  - SLT/SLTU: run the a−b carry chain.
  - At counter 31, latch the compare result into the bit-0 flag:
    - SLT: a31≠b31 ? a31 : diff31.
    - SLTU: NOT carry_out.
  - Then `counter`←0 and go to EMIT.
- EMIT: 32 cycles, `wr_en`=1; operand inputs are ignored. `data_rd` per op:
  - SLT/SLTU: bit 0 = flag, bits 1-31 = 0.
  - SLL: k≥shamt ? buf[k−shamt] : 0.
  - SRL: k+shamt≤31 ? buf[k+shamt] : 0.
  - SRA: same as SRL, but the fill bit is buf[31].
- After the last RUN/EMIT bit (counter 31): `done`=1 for one cycle with the state back in IDLE, `busy`=0. `zero` = NOR of all emitted bits.
- `counter` arithmetic: 5-bit and wraps 31→0 only on a pass transition; it holds at 0 in IDLE.
- `start` while `busy`=1 is ignored; no queueing.
- `start` on the same cycle as `done` is accepted, giving back-to-back operations.

## Timing
- Reset values: state IDLE, `counter`=0, `data_rd`=0, `wr_en`=0, `busy`=0, `done`=0, `zero`=0, carry/buffer/flag = 0.
- Reset asserted mid-operation aborts immediately to IDLE, with no partial `done`. The register-file contents written so far are not restored.
- `start` accepted at edge T: `busy`=1 and `counter`=0 from T+1. Upstream must present operand bit k in the cycle where `counter`=k.
- RUN latency: bit k is written in cycle T+1+k; `done` is high in cycle T+33.
- CAPTURE/EMIT latency: EMIT bit k in cycle T+33+k; `done` high in cycle T+65.
- `wr_en` is never high in IDLE or CAPTURE.
- `data_rd` changes only in RUN (combinationally with operand bits) or at clock edges (EMIT).

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → serial result 0x80000000. `wr_en` high exactly 32 cycles, `done` at T+33, `zero`=0.
- SUB 5 − 7 → 0xFFFFFFFE. SUB 9 − 9 → 0x00000000 with `zero`=1.
- SLT a=0xFFFFFFFF, b=1 → 0x00000001. SLTU with the same operands → 0x00000000. No `wr_en` during CAPTURE; `done` at T+65.
- SLL 0x00000001 by shamt 31 → 0x80000000. SRL 0x80000000 by 4 → 0x08000000. SRA 0x80000000 by 4 → 0xF8000000. SRA by 0 returns the operand unchanged.
- Pulse `start` with op=ADD at counter 10 of a running SRL → ignored; the SRL result is unaffected. `start` coincident with `done` → the new op begins the next cycle with `counter`=0.
- Assert `rstn`=0 at EMIT counter 5 → all outputs go to reset values asynchronously, with no `done`. After release, an ADD 3+4 → 0x00000007.
